fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core. It is the producing end of the FE→DE interface and supplies instr/pc_plus1 to decode_stage.
- Owns the word-indexed PC, issues one-outstanding requests to instruction memory, and buffers returned instructions in a small queue.
- Presents the queue head to decode with a valid/ready handshake.
- Redirects on taken branches from EX and discards all wrong-path fetches.

---
 rtl/core_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 42 ++++
 rtl/fetch_queue.sv | 70 +++++++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, the canonical NOP and the
// fetch-to-decode bundle carried through the instruction queue.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what decode sees whenever fetch has nothing valid
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus1;
  } fe_de_t;

  // Word addresses advance by one; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
    return a + XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle of the fetch stage: instruction-memory request/ack, EX redirect,
// FE->DE handshake and a few debug taps of the internal control state.
//
// Handshakes:
//   imem:  imem_req_o is a one-cycle pulse carrying imem_addr_o. At most one
//          request is outstanding; imem_ack_i (with imem_rdata_i) answers it
//          no earlier than the cycle after the request.
//   FE->DE: valid_o/de_ready_i. A transfer happens in a cycle where both are
//          high. While valid_o=1 and de_ready_i=0, instr_o/pc_plus1_o hold.
//          valid_o drops in a redirect cycle (the head is wrong-path).
interface fetch_stage_if;
  import core_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            branch_taken_i;
  logic [XLEN-1:0] branch_target_i;
  logic            de_ready_i;
  logic            valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] pc_plus1_o;
  logic            dbg_outstanding;
  logic            dbg_drop;
  logic            dbg_queue_full;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus1_o,
           dbg_outstanding, dbg_drop, dbg_queue_full,
    input  imem_ack_i, imem_rdata_i, branch_taken_i, branch_target_i,
           de_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus1_o,
           dbg_outstanding, dbg_drop, dbg_queue_full,
    output imem_ack_i, imem_rdata_i, branch_taken_i, branch_target_i,
           de_ready_i
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc_plus1} entries.
// DEPTH must be a power of two so the pointers wrap naturally.
// Flush wins over push/pop in the same cycle.
module fetch_queue
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  fe_de_t        i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output fe_de_t        o_head
);

  fe_de_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Guards keep the pointers sane even if a caller misbehaves.
  assign w_do_push = i_push && !w_full && !i_flush;
  assign w_do_pop  = i_pop && !w_empty && !i_flush;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word PC, keeps at most one request in
// flight to instruction memory, buffers returned words in fetch_queue and
// hands the queue head to decode. A taken branch from EX flushes everything
// wrong-path, including an in-flight response (tracked by r_drop).
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_outstanding;
  logic            r_drop;

  logic            w_issue;
  logic            w_ack;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  fe_de_t          w_head;
  fe_de_t          w_push_data;

  // A request only goes out when a queue slot is free for its response, so
  // the push into a full queue can never happen. Redirect suppresses issue.
  assign w_issue = rst_n && !r_outstanding && (w_count < CW'(QUEUE_DEPTH))
                   && !bus.branch_taken_i;

  // Acks without an outstanding request (e.g. pre-reset leftovers) are ignored.
  assign w_ack  = bus.imem_ack_i && r_outstanding;
  assign w_push = w_ack && !r_drop && !bus.branch_taken_i;

  assign w_valid = !w_empty && !bus.branch_taken_i;
  assign w_pop   = w_valid && bus.de_ready_i;

  assign w_push_data = '{instr: bus.imem_rdata_i, pc_plus1: next_word(r_req_pc)};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (bus.branch_taken_i),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // PC, in-flight request bookkeeping and wrong-path drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      // Response consumed (kept or discarded); any pending drop is satisfied.
      if (w_ack) begin
        r_outstanding <= 1'b0;
        r_drop        <= 1'b0;
      end
      if (bus.branch_taken_i) begin
        r_pc <= bus.branch_target_i;
        // Response still in flight belongs to the old path: swallow it later.
        if (r_outstanding && !bus.imem_ack_i) r_drop <= 1'b1;
      end else if (w_issue) begin
        r_pc          <= next_word(r_pc);
        r_req_pc      <= r_pc;
        r_outstanding <= 1'b1;
      end
    end
  end

  assign bus.imem_req_o      = w_issue;
  assign bus.imem_addr_o     = r_pc;
  assign bus.valid_o         = w_valid;
  assign bus.instr_o         = w_valid ? w_head.instr    : NOP_INSTR;
  assign bus.pc_plus1_o      = w_valid ? w_head.pc_plus1 : '0;
  assign bus.dbg_outstanding = r_outstanding;
  assign bus.dbg_drop        = r_drop;
  assign bus.dbg_queue_full  = w_full;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a memory responder with programmable
// latency (rdata = addr + 0x100), manual ack injection, and per-scenario
// tasks comparing a packed snapshot of the outputs against hand-derived values.
module tb_fetch_stage;

  typedef logic [97:0] obs_t;   // {req, addr(if req), valid, instr, pc_plus1}

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  // Stimulus controls
  logic        br;
  logic [31:0] br_tgt;
  logic        de_rdy;
  logic        man_ack;
  logic [31:0] man_rdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_en;
  logic        mem_flush;
  int          mem_lat;

  int          due_q[$];
  logic [31:0] addr_q[$];

  fetch_stage_if bus ();

  assign bus.imem_ack_i      = mem_ack | man_ack;
  assign bus.imem_rdata_i    = man_ack ? man_rdata : mem_rdata;
  assign bus.branch_taken_i  = br;
  assign bus.branch_target_i = br_tgt;
  assign bus.de_ready_i      = de_rdy;

  fetch_stage #(
    .RESET_PC    (32'h0),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack driven at period start, request sampled mid-period
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        mem_ack   = 1'b1;
        mem_rdata = addr_q[0] + 32'h100;
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end
      @(negedge clk);
      if (mem_flush) begin
        due_q.delete();
        addr_q.delete();
      end else if (mem_en && bus.imem_req_o) begin
        due_q.push_back(cyc + mem_lat);
        addr_q.push_back(bus.imem_addr_o);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic r, input logic [31:0] a, input logic v,
                              input logic [31:0] i, input logic [31:0] p);
    return {r, r ? a : 32'h0, v, i, p};
  endfunction

  function automatic obs_t observe();
    return {bus.imem_req_o, bus.imem_req_o ? bus.imem_addr_o : 32'h0,
            bus.valid_o, bus.instr_o, bus.pc_plus1_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst_n     = 1'b0;
    mem_flush = 1'b1;
    mem_en    = 1'b1;
    man_ack   = 1'b0;
    man_rdata = 32'h0;
    br        = 1'b0;
    br_tgt    = 32'h0;
    de_rdy    = 1'b1;
    tick();
    tick();
    mem_lat   = lat;
    mem_flush = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset(1);
    #3;
    tests_run++;
    o = observe();
    if (o !== mk(1'b0, 32'h0, 1'b0, NOP, 32'h0)) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req=%0b valid=%0b instr=%h pc1=%h want req=0 valid=0 instr=%h pc1=0",
               o[97], o[64], o[63:32], o[31:0], NOP);
    end
    tick();
    rst_n = 1'b1;
  endtask

  // Requests 0..3 at 1-cycle latency, a delivery every second cycle
  task automatic test_stream();
    obs_t o, e;
    int   k;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      #3;
      k = i / 2;
      if (i % 2 == 0)
        e = (k == 0) ? mk(1'b1, 32'h0, 1'b0, NOP, 32'h0)
                     : mk(1'b1, k, 1'b1, 32'h100 + k - 1, k);
      else
        e = mk(1'b0, 32'h0, 1'b0, NOP, 32'h0);
      tests_run++;
      o = observe();
      if (o !== e) begin
        tests_failed++;
        $display("FAIL stream p%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  // Decode stalls six cycles: queue fills, fetch pauses, then drains in order
  task automatic test_stall();
    obs_t o;
    obs_t e [10];
    e[0] = mk(1'b1, 32'h4, 1'b1, 32'h103, 32'h4);
    for (int i = 1; i < 7; i++) e[i] = mk(1'b0, 32'h0, 1'b1, 32'h103, 32'h4);
    e[7] = mk(1'b1, 32'h5, 1'b1, 32'h104, 32'h5);
    e[8] = mk(1'b0, 32'h0, 1'b0, NOP, 32'h0);
    e[9] = mk(1'b1, 32'h6, 1'b1, 32'h105, 32'h6);
    for (int i = 0; i < 10; i++) begin
      tick();
      de_rdy = (i >= 6);
      #3;
      tests_run++;
      o = observe();
      if (o !== e[i]) begin
        tests_failed++;
        $display("FAIL stall p%0d: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  // 4-cycle memory, redirect to 0x40 while the request to 5 is in flight
  task automatic test_redirect_drop();
    obs_t o;
    obs_t e [12];
    obs_t z;
    z = mk(1'b0, 32'h0, 1'b0, NOP, 32'h0);
    for (int i = 0; i < 12; i++) e[i] = z;
    e[1]  = mk(1'b1, 32'h5, 1'b0, NOP, 32'h0);
    e[6]  = mk(1'b1, 32'h40, 1'b0, NOP, 32'h0);
    e[11] = mk(1'b1, 32'h41, 1'b1, 32'h140, 32'h41);
    do_reset(4);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (i == 0) rst_n = 1'b1;
      br     = (i == 0) || (i == 3);
      br_tgt = (i == 0) ? 32'h5 : 32'h40;
      de_rdy = (i != 11);
      #3;
      tests_run++;
      o = observe();
      if (o !== e[i]) begin
        tests_failed++;
        $display("FAIL redirect_drop p%0d: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  // Redirect in the ack cycle with one entry queued: both discarded
  task automatic test_redirect_with_ack();
    obs_t o;
    obs_t e [7];
    for (int i = 0; i < 3; i++) e[i] = mk(1'b0, 32'h0, 1'b1, 32'h140, 32'h41);
    e[3] = mk(1'b0, 32'h0, 1'b0, NOP, 32'h0);
    e[4] = mk(1'b1, 32'h80, 1'b0, NOP, 32'h0);
    e[5] = mk(1'b0, 32'h0, 1'b0, NOP, 32'h0);
    e[6] = mk(1'b1, 32'h81, 1'b1, 32'h180, 32'h81);
    for (int i = 0; i < 7; i++) begin
      tick();
      br     = (i == 3);
      br_tgt = 32'h80;
      de_rdy = (i >= 4);
      if (i == 3) mem_lat = 1;
      #3;
      tests_run++;
      o = observe();
      if (o !== e[i]) begin
        tests_failed++;
        $display("FAIL redirect_ack p%0d: got %h want %h", i, o, e[i]);
      end
      if (i == 4) begin
        tests_run++;
        if (bus.dbg_drop !== 1'b0) begin
          tests_failed++;
          $display("FAIL redirect_ack_drop: got %0b want 0", bus.dbg_drop);
        end
      end
    end
  endtask

  // PC wraps from FFFFFFFF to 0
  task automatic test_wrap();
    obs_t o;
    obs_t e [6];
    obs_t z;
    z = mk(1'b0, 32'h0, 1'b0, NOP, 32'h0);
    e[0] = z;
    e[1] = mk(1'b1, 32'hFFFF_FFFF, 1'b0, NOP, 32'h0);
    e[2] = z;
    e[3] = mk(1'b1, 32'h0, 1'b1, 32'h0000_00FF, 32'h0);
    e[4] = z;
    e[5] = mk(1'b1, 32'h1, 1'b1, 32'h100, 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      br     = (i == 0);
      br_tgt = 32'hFFFF_FFFF;
      #3;
      tests_run++;
      o = observe();
      if (o !== e[i]) begin
        tests_failed++;
        $display("FAIL wrap p%0d: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  // Async reset mid-flight; a stale ack after release must be ignored
  task automatic test_async_reset();
    obs_t o;
    obs_t e [3];
    obs_t z;
    obs_t r [4];
    z = mk(1'b0, 32'h0, 1'b0, NOP, 32'h0);
    e[0] = z;
    e[1] = mk(1'b1, 32'h2, 1'b1, 32'h101, 32'h2);
    e[2] = mk(1'b0, 32'h0, 1'b1, 32'h101, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      de_rdy = 1'b0;
      if (i == 1) mem_lat = 3;
      #3;
      tests_run++;
      o = observe();
      if (o !== e[i]) begin
        tests_failed++;
        $display("FAIL pre_reset p%0d: got %h want %h", i, o, e[i]);
      end
    end
    rst_n     = 1'b0;
    mem_flush = 1'b1;
    mem_en    = 1'b0;
    #1;
    tests_run++;
    o = observe();
    if (o !== z) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %h want %h", o, z);
    end
    tests_run++;
    if (bus.dbg_outstanding !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_outstanding: got %0b want 0", bus.dbg_outstanding);
    end
    tick();
    tick();
    r[0] = mk(1'b1, 32'h0, 1'b0, NOP, 32'h0);
    r[1] = z;
    r[2] = z;
    r[3] = mk(1'b1, 32'h1, 1'b1, 32'h500, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        rst_n     = 1'b1;
        mem_flush = 1'b0;
      end
      man_ack   = (i == 0) || (i == 2);
      man_rdata = (i == 0) ? 32'hDEAD_BEEF : 32'h500;
      de_rdy    = (i == 3);
      #3;
      tests_run++;
      o = observe();
      if (o !== r[i]) begin
        tests_failed++;
        $display("FAIL post_reset p%0d: got %h want %h", i, o, r[i]);
      end
    end
    man_ack = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    br        = 1'b0;
    br_tgt    = 32'h0;
    de_rdy    = 1'b1;
    man_ack   = 1'b0;
    man_rdata = 32'h0;
    mem_en    = 1'b1;
    mem_flush = 1'b0;
    mem_lat   = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_with_ack();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
